hci_core_demux_static: RTL

//  Statically steers one HCI core initiator stream onto one of NB_CHAN target-side HCI ports, chosen by sel_i.
//  - Mirrors the static N:1 mux: one upstream master reaches alternative memory paths, e.g. TCDM vs. a

---
 rtl/hci_core_demux_static_pkg.sv | 17 +
 rtl/hci_core_demux_static_cnt.sv | 42 ++++
 rtl/hci_core_demux_static.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/hci_core_demux_static_pkg.sv
// Shared types and helpers for the static HCI core demultiplexer and its
// outstanding-transaction counter.
package hci_core_demux_static_pkg;

    // ROUTE forwards traffic to the selected channel; DRAIN holds off new
    // requests until every response of the old channel has come back.
    typedef enum logic {
        ROUTE = 1'b0,
        DRAIN = 1'b1
    } hci_demux_static_state_e;

    // Width of a counter that must hold every value from 0 to max_outstanding.
    function automatic int hci_cnt_width(input int max_outstanding);
        return $clog2(max_outstanding + 1);
    endfunction

endpackage

// File: rtl/hci_core_demux_static_cnt.sv
// Saturating up/down counter of granted-but-unanswered HCI transactions.
// Increment and decrement in the same cycle cancel. Increments stop at MAX.
// Decrements at zero are not guarded here. The owner masks dec when underflow
// must be prevented.
module hci_outstanding_cnt
    import hci_core_demux_static_pkg::*;
#(
    parameter  int MAX = 4,
    localparam int CW  = hci_cnt_width(MAX)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          inc,
    input  logic          dec,
    input  logic          clear,
    output logic [CW-1:0] cnt_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [CW-1:0] cnt_q;

    // Count grants up and retired responses down, holding at MAX.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (inc && !dec) begin
            if (cnt_q != CW'(MAX)) begin
                cnt_q <= cnt_q + CW'(1);
            end
        end else if (dec && !inc) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign cnt_o   = cnt_q;
    assign full_o  = (cnt_q == CW'(MAX));
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/hci_core_demux_static.sv
// Static 1:NB_CHAN demultiplexer for an HCI core initiator stream.
// The channel is picked by sel_i. A change of sel_i takes effect only once
// every outstanding response of the old channel has returned, so responses
// can never be misrouted.
// The HCI bundle appears as flat in_* / out_* ports. Per-channel signals are
// packed arrays indexed by channel. One parameter set is shared by the
// upstream port and every downstream port, so their widths always agree.
// Optional feature: define HCI_CORE_DEMUX_STATIC_ERR_EN to enable the sticky
// protocol-error flag and underflow protection. Without it, err_o is tied low.
module hci_core_demux_static
    import hci_core_demux_static_pkg::*;
#(
    parameter  int NB_CHAN         = 2,
    parameter  int MAX_OUTSTANDING = 4,
    parameter  int DW              = 32,
    parameter  int AW              = 32,
    parameter  int BW              = DW / 8,
    parameter  int UW              = 1,
    parameter  int IW              = 1,
    parameter  int EW              = 1,
    parameter  int EHW             = 1,
    localparam int SW              = $clog2(NB_CHAN),
    localparam int EHWP            = (EHW > 0) ? EHW : 1,
    localparam int CW              = hci_cnt_width(MAX_OUTSTANDING)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           clear_i,
    input  logic [SW-1:0]                  sel_i,
    // upstream initiator (target side of this block)
    input  logic                           in_req,
    output logic                           in_gnt,
    input  logic [AW-1:0]                  in_add,
    input  logic                           in_wen,
    input  logic [BW-1:0]                  in_be,
    input  logic [DW-1:0]                  in_data,
    input  logic [UW-1:0]                  in_user,
    input  logic [IW-1:0]                  in_id,
    input  logic [EW-1:0]                  in_ecc,
    input  logic                           in_r_ready,
    output logic                           in_r_valid,
    output logic [DW-1:0]                  in_r_data,
    output logic [UW-1:0]                  in_r_user,
    output logic [IW-1:0]                  in_r_id,
    output logic [EW-1:0]                  in_r_ecc,
    output logic [EHWP-1:0]                in_egnt,
    output logic [EHWP-1:0]                in_r_evalid,
    // downstream channels (initiator side of this block)
    output logic [NB_CHAN-1:0]             out_req,
    input  logic [NB_CHAN-1:0]             out_gnt,
    output logic [NB_CHAN-1:0][AW-1:0]     out_add,
    output logic [NB_CHAN-1:0]             out_wen,
    output logic [NB_CHAN-1:0][BW-1:0]     out_be,
    output logic [NB_CHAN-1:0][DW-1:0]     out_data,
    output logic [NB_CHAN-1:0][UW-1:0]     out_user,
    output logic [NB_CHAN-1:0][IW-1:0]     out_id,
    output logic [NB_CHAN-1:0][EW-1:0]     out_ecc,
    output logic [NB_CHAN-1:0]             out_r_ready,
    input  logic [NB_CHAN-1:0]             out_r_valid,
    input  logic [NB_CHAN-1:0][DW-1:0]     out_r_data,
    input  logic [NB_CHAN-1:0][UW-1:0]     out_r_user,
    input  logic [NB_CHAN-1:0][IW-1:0]     out_r_id,
    input  logic [NB_CHAN-1:0][EW-1:0]     out_r_ecc,
    output logic [NB_CHAN-1:0][EHWP-1:0]   out_ereq,
    output logic [NB_CHAN-1:0][EHWP-1:0]   out_r_eready,
    input  logic [NB_CHAN-1:0][EHWP-1:0]   out_r_evalid,
    // status
    output logic                           busy_o,
    output logic                           err_o
);

    hci_demux_static_state_e state_q, state_d;
    logic [SW-1:0]      sel_q, sel_d;
    logic [NB_CHAN-1:0] sel_mask;
    logic [CW-1:0]      cnt_q;
    logic               cnt_full, cnt_empty;
    logic               route_ok, grant, retire, dec_en, switch_ok;

    // One-hot view of the currently routed channel.
    always_comb begin
        sel_mask        = '0;
        sel_mask[sel_q] = 1'b1;
    end

    // Requests flow only while routing with room left for another transaction.
    assign route_ok = (state_q == ROUTE) && !cnt_full;
    assign in_gnt   = route_ok && out_gnt[sel_q];
    assign out_req  = route_ok ? (sel_mask & {NB_CHAN{in_req}}) : '0;
    assign grant    = in_req && in_gnt;

    // Request payload fans out to every channel. Only the selected one sees req.
    assign out_add  = {NB_CHAN{in_add}};
    assign out_wen  = {NB_CHAN{in_wen}};
    assign out_be   = {NB_CHAN{in_be}};
    assign out_data = {NB_CHAN{in_data}};
    assign out_user = {NB_CHAN{in_user}};
    assign out_id   = {NB_CHAN{in_id}};
    assign out_ecc  = {NB_CHAN{in_ecc}};

    // Responses always come from the routed channel, even while draining.
    assign in_r_valid  = out_r_valid[sel_q];
    assign in_r_data   = out_r_data[sel_q];
    assign in_r_user   = out_r_user[sel_q];
    assign in_r_id     = out_r_id[sel_q];
    assign in_r_ecc    = out_r_ecc[sel_q];
    assign out_r_ready = sel_mask & {NB_CHAN{in_r_ready}};
    assign retire      = in_r_valid && in_r_ready;

    if (EHW > 0) begin : g_ecc
        assign in_egnt     = {EHW{in_gnt}};
        assign in_r_evalid = out_r_evalid[sel_q];
        for (genvar i = 0; i < NB_CHAN; i++) begin : g_ch
            assign out_ereq[i]     = {EHW{out_req[i]}};
            assign out_r_eready[i] = {EHW{out_r_ready[i]}};
        end
    end else begin : g_no_ecc
        assign in_egnt      = '1;
        assign in_r_evalid  = '0;
        assign out_ereq     = '0;
        assign out_r_eready = '1;
    end

`ifdef HCI_CORE_DEMUX_STATIC_ERR_EN
    logic err_q;
    logic stray_rsp;

    // A response with nothing outstanding would corrupt the count, so drop it.
    assign dec_en    = retire && !cnt_empty;
    assign stray_rsp = |(out_r_valid & ~sel_mask);

    // Sticky flag for responses on the wrong channel or with nothing pending.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (clear_i) begin
            err_q <= 1'b0;
        end else if (stray_rsp || (in_r_valid && cnt_empty)) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    assign dec_en = retire;
    assign err_o  = 1'b0;
`endif

    hci_outstanding_cnt #(
        .MAX     (MAX_OUTSTANDING)
    ) i_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc     (grant),
        .dec     (dec_en),
        .clear   (clear_i),
        .cnt_o   (cnt_q),
        .full_o  (cnt_full),
        .empty_o (cnt_empty)
    );

    // The old channel is clean when empty now, or when its last beat retires this cycle.
    assign switch_ok = cnt_empty || ((cnt_q == CW'(1)) && dec_en && !grant);

    // Next state: leave ROUTE on a new selection, leave DRAIN once the old channel is clean.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        case (state_q)
            ROUTE: begin
                if (sel_i != sel_q) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (switch_ok) begin
                    state_d = ROUTE;
                    sel_d   = sel_i;
                end
            end
            default: state_d = ROUTE;
        endcase
    end

    // State and selection registers. A soft clear adopts sel_i at once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ROUTE;
            sel_q   <= '0;
        end else if (clear_i) begin
            state_q <= ROUTE;
            sel_q   <= sel_i;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

    assign busy_o = !cnt_empty || (state_q == DRAIN);

endmodule
